// File: rtl/track_pkg.sv
// -----------------------------------------------------------------------------
// track_pkg
// Shared constants and helpers for the track painter.
//   COLOR_W / CNT_W          : pixel colour width and timing counter width
//   DEF_COLOR_*              : default border, line and field colours
//   divider_x()              : left x of lane divider k, evaluated at elaboration
// Optional feature macro used by draw_track: TRACK_FINISH_LINE_EN
// -----------------------------------------------------------------------------
package track_pkg;

    localparam int COLOR_W = 12;
    localparam int CNT_W   = 11;

    localparam logic [COLOR_W-1:0] DEF_COLOR_BORDER = 12'hfff;
    localparam logic [COLOR_W-1:0] DEF_COLOR_LINE   = 12'hfff;
    localparam logic [COLOR_W-1:0] DEF_COLOR_FIELD  = 12'h000;

    // Dividers split the inner width evenly; floor division happens at
    // elaboration only, so no divider hardware is built.
    function automatic int divider_x(input int xRect, input int border,
                                     input int width, input int lanes,
                                     input int k);
        return xRect + border + (k * (width - 2 * border)) / lanes;
    endfunction

endpackage

// File: rtl/track_scroll.sv
// -----------------------------------------------------------------------------
// track_scroll
// Per-frame dash phase generator. A frame tick is the rising edge of vertical
// blanking; on each tick with run_i set the phase advances by speed_i lines,
// wrapping naturally at DASH_PERIOD (a power of two).
// Ports:
//   clk, rst_n     : pixel clock, asynchronous active-low reset
//   vblnk_i        : vertical blanking from the timing generator
//   run_i          : 1 = scroll, 0 = hold phase
//   speed_i        : phase step per frame, in lines
//   scroll_off_o   : current dash phase
// -----------------------------------------------------------------------------
module track_scroll
    import track_pkg::*;
#(
    parameter  int DASH_PERIOD = 32,
    localparam int SW          = $clog2(DASH_PERIOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vblnk_i,
    input  logic          run_i,
    input  logic [3:0]    speed_i,
    output logic [SW-1:0] scroll_off_o
);

    logic          vblnk_q;
    logic          tick;
    logic [SW-1:0] scroll_q;
    logic [SW-1:0] scroll_d;

    assign tick = vblnk_i & ~vblnk_q;

    // Phase advance: the SW-bit add truncates, which is exactly the modulo
    // wrap of a power-of-two period. run/speed are only looked at on a tick.
    always_comb begin
        scroll_d = scroll_q;
        if (tick && run_i) begin
            scroll_d = scroll_q + SW'(speed_i);
        end
    end

    // vblnk_q is the one-cycle delayed blanking used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q  <= 1'b0;
            scroll_q <= '0;
        end else begin
            vblnk_q  <= vblnk_i;
            scroll_q <= scroll_d;
        end
    end

    assign scroll_off_o = scroll_q;

endmodule

// File: rtl/draw_track.sv
// -----------------------------------------------------------------------------
// draw_track
// Paints a scrolling race track into the VGA stream: bordered rectangle, two
// solid edge lines and LANES-1 dashed lane dividers. All timing signals and
// the pixel colour are registered once (1-cycle latency).
// Ports:
//   pclk, rst_n               : pixel clock, asynchronous active-low reset
//   hcount_in, vcount_in      : pixel position
//   hsync/vsync/hblnk/vblnk_in: timing from the generator
//   run, speed                : scroll enable and per-frame step
//   *_out                     : registered timing, rgb_out aligned to them
//   scroll_off                : current dash phase
// Optional feature: define TRACK_FINISH_LINE_EN for a static checkered
// finish band inside the track.
// -----------------------------------------------------------------------------
module draw_track
    import track_pkg::*;
#(
    parameter int X_RECT      = 10,
    parameter int Y_RECT      = 90,
    parameter int WIDTH       = 780,
    parameter int HEIGHT      = 500,
    parameter int BORDER      = 5,
    parameter int EDGE_OFF    = 50,
    parameter int LINE_W      = 6,
    parameter int LANES       = 3,
    parameter int DASH_PERIOD = 32,
    parameter int DASH_ON     = 16,
    parameter logic [COLOR_W-1:0] COLOR_BORDER = DEF_COLOR_BORDER,
    parameter logic [COLOR_W-1:0] COLOR_LINE   = DEF_COLOR_LINE,
    parameter logic [COLOR_W-1:0] COLOR_FIELD  = DEF_COLOR_FIELD
) (
    input  logic                           pclk,
    input  logic                           rst_n,
    input  logic [CNT_W-1:0]               hcount_in,
    input  logic [CNT_W-1:0]               vcount_in,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic                           hblnk_in,
    input  logic                           vblnk_in,
    input  logic                           run,
    input  logic [3:0]                     speed,
    output logic [CNT_W-1:0]               hcount_out,
    output logic [CNT_W-1:0]               vcount_out,
    output logic                           hsync_out,
    output logic                           vsync_out,
    output logic                           hblnk_out,
    output logic                           vblnk_out,
    output logic [COLOR_W-1:0]             rgb_out,
    output logic [$clog2(DASH_PERIOD)-1:0] scroll_off
);

    localparam int SW        = $clog2(DASH_PERIOD);
    localparam int LEFT_X    = X_RECT + EDGE_OFF;
    localparam int RIGHT_X   = X_RECT + WIDTH - EDGE_OFF - LINE_W;
    localparam int DASH_BASE = Y_RECT + BORDER;

    int               hPix;
    int               vPix;
    logic             inRect;
    logic             inInner;
    logic             onEdge;
    logic             onDivider;
    logic             dashOn;
    logic [SW-1:0]    dashPos;
    logic [LANES-1:0] divHit;
    logic [COLOR_W-1:0] rgb_d;

    logic [CNT_W-1:0]   hcount_q;
    logic [CNT_W-1:0]   vcount_q;
    logic               hsync_q;
    logic               vsync_q;
    logic               hblnk_q;
    logic               vblnk_q;
    logic [COLOR_W-1:0] rgb_q;

    track_scroll #(
        .DASH_PERIOD (DASH_PERIOD)
    ) u_scroll (
        .clk          (pclk),
        .rst_n        (rst_n),
        .vblnk_i      (vblnk_in),
        .run_i        (run),
        .speed_i      (speed),
        .scroll_off_o (scroll_off)
    );

    assign hPix = int'(hcount_in);
    assign vPix = int'(vcount_in);

    assign inRect  = (hPix >= X_RECT) && (hPix < X_RECT + WIDTH) &&
                     (vPix >= Y_RECT) && (vPix < Y_RECT + HEIGHT);
    assign inInner = (hPix >= X_RECT + BORDER) && (hPix < X_RECT + WIDTH - BORDER) &&
                     (vPix >= Y_RECT + BORDER) && (vPix < Y_RECT + HEIGHT - BORDER);

    assign onEdge = ((hPix >= LEFT_X)  && (hPix < LEFT_X + LINE_W)) ||
                    ((hPix >= RIGHT_X) && (hPix < RIGHT_X + LINE_W));

    // Index 0 is tied low and never marks a divider, so LANES = 1 still
    // yields a legal vector with no dividers drawn.
    assign divHit[0] = 1'b0;
    for (genvar k = 1; k < LANES; k++) begin : g_div
        localparam int DX = divider_x(X_RECT, BORDER, WIDTH, LANES, k);
        assign divHit[k] = (hPix >= DX) && (hPix < DX + LINE_W);
    end
    assign onDivider = |divHit;

    // Only the low SW bits matter: the period is a power of two, so the
    // truncated arithmetic is the modulo (also for rows above the base).
    assign dashPos = SW'(vcount_in) - SW'(DASH_BASE) + scroll_off;
    assign dashOn  = (dashPos < SW'(DASH_ON));

`ifdef TRACK_FINISH_LINE_EN
    localparam int FINISH_Y = Y_RECT + 40;
    localparam int FINISH_H = 8;
    logic inFinish;
    assign inFinish = inInner && (vPix >= FINISH_Y) && (vPix < FINISH_Y + FINISH_H);
`endif

    // Colour priority: blanking, outside, border, finish band, lines, field.
    always_comb begin
        rgb_d = '0;
        if (hblnk_in || vblnk_in) begin
            rgb_d = '0;
        end else if (!inRect) begin
            rgb_d = '0;
        end else if (!inInner) begin
            rgb_d = COLOR_BORDER;
`ifdef TRACK_FINISH_LINE_EN
        end else if (inFinish) begin
            rgb_d = (hcount_in[2] ^ vcount_in[2]) ? COLOR_LINE : COLOR_FIELD;
`endif
        end else if (onEdge || (onDivider && dashOn)) begin
            rgb_d = COLOR_LINE;
        end else begin
            rgb_d = COLOR_FIELD;
        end
    end

    // Single pipeline stage keeping colour aligned with the timing signals.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= hcount_in;
            vcount_q <= vcount_in;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hblnk_q  <= hblnk_in;
            vblnk_q  <= vblnk_in;
            rgb_q    <= rgb_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign hblnk_out  = hblnk_q;
    assign vblnk_out  = vblnk_q;
    assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_track.sv
// -----------------------------------------------------------------------------
// tb_draw_track
// Scoreboard bench for draw_track with default parameters. Each driven pixel
// pushes its expected registered outputs into a queue; a monitor pops one
// entry per clock and compares. Expected colours come from a geometric model
// of the track. Honours TRACK_FINISH_LINE_EN like the design.
// -----------------------------------------------------------------------------
module tb_draw_track;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [4:0]  sc;
    } expT;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  speed = '0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic [4:0]  scroll_off;

    int   errors = 0;
    int   checks = 0;
    expT  expQ[$];
    int   mScroll = 0;
    bit   mVblnkD = 1'b0;
    bit   runNext = 1'b0;
    int   speedNext = 0;

    draw_track dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .run        (run),
        .speed      (speed),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .scroll_off (scroll_off)
    );

    always #5 pclk = ~pclk;

    // Track picture for the default geometry: rectangle 10..789 x 90..589,
    // 5-pixel border, edge lines at 60 and 734, dividers at 15+k*770/3,
    // all 6 wide, dashes 16 on / 16 off measured from row 95.
    function automatic logic [11:0] modelRgb(input int h, input int v,
                                             input bit hb, input bit vb,
                                             input int sc);
        int dx;
        if (hb || vb) return 12'h000;
        if (!(h >= 10 && h < 790 && v >= 90 && v < 590)) return 12'h000;
        if (!(h >= 15 && h < 785 && v >= 95 && v < 585)) return 12'hfff;
`ifdef TRACK_FINISH_LINE_EN
        if (v >= 130 && v < 138)
            return (((h / 4) % 2) != ((v / 4) % 2)) ? 12'hfff : 12'h000;
`endif
        if ((h >= 60 && h < 66) || (h >= 734 && h < 740)) return 12'hfff;
        for (int k = 1; k < 3; k++) begin
            dx = 15 + (k * 770) / 3;
            if (h >= dx && h < dx + 6 && ((v - 95 + sc) % 32) < 16) return 12'hfff;
        end
        return 12'h000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Drives one pixel at the falling edge and records what the DUT must show
    // after the next rising edge; the frame phase is advanced on the model's
    // own view of a vertical blanking rise.
    task automatic applyStimulus(input int h, input int v, input bit hb, input bit vb);
        expT e;
        @(negedge pclk);
        hcount_in = h[10:0];
        vcount_in = v[10:0];
        hsync_in  = 1'($urandom_range(0, 1));
        vsync_in  = 1'($urandom_range(0, 1));
        hblnk_in  = hb;
        vblnk_in  = vb;
        run       = runNext;
        speed     = 4'(speedNext);
        e.h   = h[10:0];
        e.v   = v[10:0];
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        e.hb  = hb;
        e.vb  = vb;
        e.rgb = modelRgb(h, v, hb, vb, mScroll);
        if (vb && !mVblnkD && runNext) mScroll = (mScroll + speedNext) % 32;
        mVblnkD = vb;
        e.sc  = 5'(mScroll);
        expQ.push_back(e);
    endtask

    task automatic frameTick();
        applyStimulus(5, 5, 1'b0, 1'b0);
        applyStimulus(5, 5, 1'b0, 1'b1);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, 64'({hcount_out, vcount_out, hsync_out, vsync_out,
                               hblnk_out, vblnk_out, rgb_out, scroll_off}), 64'd0);
    endtask

    always @(posedge pclk) begin
        expT e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("timing(%0d,%0d)", e.h, e.v),
                        64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                        64'({e.h, e.v, e.hs, e.vs, e.hb, e.vb}));
            checkOutput($sformatf("rgb(%0d,%0d)", e.h, e.v), 64'(rgb_out), 64'(e.rgb));
            checkOutput($sformatf("scroll(%0d,%0d)", e.h, e.v), 64'(scroll_off), 64'(e.sc));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int picks[17] = '{10, 14, 15, 60, 65, 66, 271, 276, 277, 528, 533,
                          734, 739, 740, 785, 789, 790};
        int h;
        int v;

        // Power-on reset
        #12;
        checkAllZero("reset_initial");
        @(negedge pclk);
        rst_n = 1'b1;

        // Static pixels, phase 0
        applyStimulus(10, 90, 1'b0, 1'b0);
        applyStimulus(5, 90, 1'b0, 1'b0);
        applyStimulus(300, 300, 1'b1, 1'b0);
        applyStimulus(60, 200, 1'b0, 1'b0);
        applyStimulus(271, 95, 1'b0, 1'b0);
        applyStimulus(271, 111, 1'b0, 1'b0);
        applyStimulus(528, 95, 1'b0, 1'b0);
        applyStimulus(400, 95, 1'b0, 1'b0);
        applyStimulus(271, 108, 1'b0, 1'b0);
        applyStimulus(271, 130, 1'b0, 1'b0);
        applyStimulus(275, 130, 1'b0, 1'b0);

        // One tick at speed 3 moves row 108 off its dash
        runNext = 1'b1;
        speedNext = 3;
        frameTick();
        applyStimulus(271, 108, 1'b0, 1'b0);
        @(posedge pclk);
        #3;
        checkOutput("scroll_after_tick", 64'(scroll_off), 64'd3);

        // Reset mid-line with a lit border pixel on the outputs
        applyStimulus(10, 90, 1'b0, 1'b0);
        @(posedge pclk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_midline");
        @(posedge pclk);
        #3;
        checkAllZero("reset_held");
        @(negedge pclk);
        rst_n = 1'b1;
        mScroll = 0;
        mVblnkD = 1'b0;

        // Wrap: three ticks of 15 from 0
        speedNext = 15;
        repeat (3) frameTick();
        @(posedge pclk);
        #3;
        checkOutput("scroll_wrap", 64'(scroll_off), 64'd13);

        // Pause holds the phase across ticks
        runNext = 1'b0;
        repeat (2) frameTick();
        @(posedge pclk);
        #3;
        checkOutput("scroll_paused", 64'(scroll_off), 64'd13);

        // Speed change mid-frame waits for the next tick
        runNext = 1'b1;
        applyStimulus(300, 300, 1'b0, 1'b0);
        speedNext = 9;
        applyStimulus(271, 300, 1'b0, 1'b0);
        applyStimulus(528, 301, 1'b0, 1'b0);
        applyStimulus(5, 5, 1'b0, 1'b1);
        @(posedge pclk);
        #3;
        checkOutput("scroll_speed_change", 64'(scroll_off), 64'd22);

        // Randomised frames
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                speedNext = $urandom_range(0, 15);
                runNext = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 1)
                h = picks[$urandom_range(0, 16)] + int'($urandom_range(0, 4)) - 2;
            else
                h = $urandom_range(0, 799);
            v = $urandom_range(85, 600);
            applyStimulus(h, v, ($urandom_range(0, 7) == 0), ((i % 40) >= 36));
        end

        repeat (3) @(posedge pclk);
        #3;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
